core_id_pipe: RTL and testbench

Registered, handshaked successor to the combinational instruction-decode stage. Sits between IF and EX. Decodes RV32I (optionally RV32M) into control flags, register addresses and immediates. Adds a valid/ready pipeline register, an optional 1-entry skid buffer, flush support and illegal-instruction detection.

---
 rtl/core_id_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_core_id_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_id_pipe.sv
// Registered RV32I(M) instruction-decode stage between IF and EX.
// Valid/ready handshake with an optional 1-entry skid buffer, flush and illegal detection.
module core_id_pipe #(
  parameter bit M_EXT   = 1'b1,
  parameter bit SKID_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready_ex,
  output logic [31:0] o_pc,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc_plus_imm,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic        o_rs1_en,
  output logic        o_rs2_en,
  output logic        o_rd_wen,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_branch_may,
  output logic        o_nextpc2reg,
  output logic        o_alures2reg,
  output logic        o_memory2reg,
  output logic        o_mem_write,
  output logic        o_muldiv,
  output logic        o_system,
  output logic        o_fence,
  output logic [6:0]  o_opcode,
  output logic [6:0]  o_funct7,
  output logic [2:0]  o_funct3,
  output logic        o_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALI    = 7'b0010011;
  localparam logic [6:0] OP_ALR    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc_plus_imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_wen;
    logic        jal;
    logic        jalr;
    logic        branch_may;
    logic        nextpc2reg;
    logic        alures2reg;
    logic        memory2reg;
    logic        mem_write;
    logic        muldiv;
    logic        system;
    logic        fence;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } state_t;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  logic [31:0] w_imm;
  logic        w_rs1_en;
  logic        w_rs2_en;
  logic        w_writes;
  logic        w_jal;
  logic        w_jalr;
  logic        w_branch;
  logic        w_alu;
  logic        w_load;
  logic        w_store;
  logic        w_muldiv;
  logic        w_system;
  logic        w_fence;
  logic        w_illegal;
  dec_t        w_dec;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_out_vld;
  logic        r_in_ready;
  dec_t        r_out;
  dec_t        r_skid;
  logic        w_accept;
  logic        w_xfer;
  logic        w_ld_out_dec;
  logic        w_ld_out_skid;
  logic        w_ld_skid;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];
  assign w_rd = i_instr[11:7];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'h000};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  // Opcode classification; opcodes with instr[1:0] != 11 fall into the default arm.
  always_comb begin
    w_imm     = '0;
    w_rs1_en  = 1'b0;
    w_rs2_en  = 1'b0;
    w_writes  = 1'b0;
    w_jal     = 1'b0;
    w_jalr    = 1'b0;
    w_branch  = 1'b0;
    w_alu     = 1'b0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_muldiv  = 1'b0;
    w_system  = 1'b0;
    w_fence   = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_LUI, OP_AUIPC: begin
        w_imm    = w_imm_u;
        w_writes = 1'b1;
        w_alu    = 1'b1;
      end
      OP_JAL: begin
        w_imm    = w_imm_j;
        w_writes = 1'b1;
        w_jal    = 1'b1;
      end
      OP_JALR: begin
        w_imm     = w_imm_i;
        w_rs1_en  = 1'b1;
        w_writes  = 1'b1;
        w_jalr    = 1'b1;
        w_illegal = (w_f3 != 3'b000);
      end
      OP_BRANCH: begin
        w_imm     = w_imm_b;
        w_rs1_en  = 1'b1;
        w_rs2_en  = 1'b1;
        w_branch  = 1'b1;
        w_illegal = (w_f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        w_imm     = w_imm_i;
        w_rs1_en  = 1'b1;
        w_writes  = 1'b1;
        w_load    = 1'b1;
        w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        w_imm     = w_imm_s;
        w_rs1_en  = 1'b1;
        w_rs2_en  = 1'b1;
        w_store   = 1'b1;
        w_illegal = (w_f3 > 3'b010);
      end
      OP_ALI: begin
        w_imm    = w_imm_i;
        w_rs1_en = 1'b1;
        w_writes = 1'b1;
        w_alu    = 1'b1;
        if (w_f3 == 3'b001) begin
          w_illegal = (w_f7 != F7_ZERO);
        end else if (w_f3 == 3'b101) begin
          w_illegal = (w_f7 != F7_ZERO) && (w_f7 != F7_ALT);
        end
      end
      OP_ALR: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_writes = 1'b1;
        w_alu    = 1'b1;
        if (w_f7 == F7_ZERO) begin
          w_illegal = 1'b0;
        end else if (w_f7 == F7_ALT) begin
          w_illegal = (w_f3 != 3'b000) && (w_f3 != 3'b101);
        end else if ((w_f7 == F7_MULDIV) && M_EXT) begin
          w_muldiv = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_FENCE: begin
        w_fence = 1'b1;
      end
      OP_SYSTEM: begin
        w_system = 1'b1;
        w_rs1_en = (w_f3 != 3'b000);
        w_writes = (w_f3 != 3'b000);
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Side-effecting controls are suppressed on illegal encodings so EX only sees a trap.
  always_comb begin
    w_dec             = '0;
    w_dec.pc          = i_pc;
    w_dec.imm         = w_imm;
    w_dec.pc_plus_imm = i_pc + w_imm;
    w_dec.rs1_addr    = i_instr[19:15];
    w_dec.rs2_addr    = i_instr[24:20];
    w_dec.rd_addr     = w_rd;
    w_dec.rs1_en      = w_rs1_en;
    w_dec.rs2_en      = w_rs2_en;
    w_dec.rd_wen      = w_writes && (w_rd != 5'd0) && !w_illegal;
    w_dec.jal         = w_jal && !w_illegal;
    w_dec.jalr        = w_jalr && !w_illegal;
    w_dec.branch_may  = w_branch && !w_illegal;
    w_dec.nextpc2reg  = w_jal || w_jalr;
    w_dec.alures2reg  = w_alu;
    w_dec.memory2reg  = w_load && !w_illegal;
    w_dec.mem_write   = w_store && !w_illegal;
    w_dec.muldiv      = w_muldiv && !w_illegal;
    w_dec.system      = w_system;
    w_dec.fence       = w_fence;
    w_dec.opcode      = w_op;
    w_dec.funct7      = w_f7;
    w_dec.funct3      = w_f3;
    w_dec.illegal     = w_illegal;
  end

  assign i_ready  = SKID_EN ? r_in_ready : (!r_out_vld || i_ready_ex);
  assign w_accept = i_valid && i_ready;
  assign w_xfer   = r_out_vld && i_ready_ex;

  // Occupancy FSM; without the skid, accept in FULL1 always coincides with a transfer.
  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out_dec  = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = ST_FULL1;
          w_ld_out_dec = 1'b1;
        end
      end
      ST_FULL1: begin
        if (w_accept && w_xfer) begin
          w_ld_out_dec = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL2;
          w_ld_skid   = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (w_xfer) begin
          w_state_nxt   = ST_FULL1;
          w_ld_out_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (i_flush) begin
      w_state_nxt   = ST_EMPTY;
      w_ld_out_dec  = 1'b0;
      w_ld_out_skid = 1'b0;
      w_ld_skid     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_out_vld  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_out_vld  <= (w_state_nxt != ST_EMPTY);
      r_in_ready <= (w_state_nxt != ST_FULL2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out_dec) begin
        r_out <= w_dec;
      end else if (w_ld_out_skid) begin
        r_out <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign o_valid       = r_out_vld;
  assign o_pc          = r_out.pc;
  assign o_imm         = r_out.imm;
  assign o_pc_plus_imm = r_out.pc_plus_imm;
  assign o_rs1_addr    = r_out.rs1_addr;
  assign o_rs2_addr    = r_out.rs2_addr;
  assign o_rd_addr     = r_out.rd_addr;
  assign o_rs1_en      = r_out.rs1_en;
  assign o_rs2_en      = r_out.rs2_en;
  assign o_rd_wen      = r_out.rd_wen;
  assign o_jal         = r_out.jal;
  assign o_jalr        = r_out.jalr;
  assign o_branch_may  = r_out.branch_may;
  assign o_nextpc2reg  = r_out.nextpc2reg;
  assign o_alures2reg  = r_out.alures2reg;
  assign o_memory2reg  = r_out.memory2reg;
  assign o_mem_write   = r_out.mem_write;
  assign o_muldiv      = r_out.muldiv;
  assign o_system      = r_out.system;
  assign o_fence       = r_out.fence;
  assign o_opcode      = r_out.opcode;
  assign o_funct7      = r_out.funct7;
  assign o_funct3      = r_out.funct3;
  assign o_illegal     = r_out.illegal;

endmodule

// File: tb/tb_core_id_pipe.sv
// Bench for core_id_pipe: queue-based occupancy model plus rule-level decode reference.
module tb_core_id_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic        i_ready_ex = 1'b0;

  logic        i_ready, o_valid;
  logic [31:0] o_pc, o_imm, o_pc_plus_imm;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic        o_rs1_en, o_rs2_en, o_rd_wen, o_jal, o_jalr, o_branch_may, o_nextpc2reg;
  logic        o_alures2reg, o_memory2reg, o_mem_write, o_muldiv, o_system, o_fence, o_illegal;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;

  logic        n_ready, n_valid;
  logic [31:0] n_pc, n_imm, n_pc_plus_imm;
  logic [4:0]  n_rs1_addr, n_rs2_addr, n_rd_addr;
  logic        n_rs1_en, n_rs2_en, n_rd_wen, n_jal, n_jalr, n_branch_may, n_nextpc2reg;
  logic        n_alures2reg, n_memory2reg, n_mem_write, n_muldiv, n_system, n_fence, n_illegal;
  logic [6:0]  n_opcode, n_funct7;
  logic [2:0]  n_funct3;

  always #5 clk = ~clk;

  core_id_pipe #(.M_EXT(1'b1), .SKID_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .i_ready(i_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid), .i_ready_ex(i_ready_ex),
    .o_pc(o_pc), .o_imm(o_imm), .o_pc_plus_imm(o_pc_plus_imm),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_rs1_en(o_rs1_en), .o_rs2_en(o_rs2_en), .o_rd_wen(o_rd_wen),
    .o_jal(o_jal), .o_jalr(o_jalr), .o_branch_may(o_branch_may),
    .o_nextpc2reg(o_nextpc2reg), .o_alures2reg(o_alures2reg),
    .o_memory2reg(o_memory2reg), .o_mem_write(o_mem_write), .o_muldiv(o_muldiv),
    .o_system(o_system), .o_fence(o_fence), .o_opcode(o_opcode), .o_funct7(o_funct7),
    .o_funct3(o_funct3), .o_illegal(o_illegal)
  );

  core_id_pipe #(.M_EXT(1'b0), .SKID_EN(1'b1)) u_dut_nm (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .i_ready(n_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(n_valid), .i_ready_ex(i_ready_ex),
    .o_pc(n_pc), .o_imm(n_imm), .o_pc_plus_imm(n_pc_plus_imm),
    .o_rs1_addr(n_rs1_addr), .o_rs2_addr(n_rs2_addr), .o_rd_addr(n_rd_addr),
    .o_rs1_en(n_rs1_en), .o_rs2_en(n_rs2_en), .o_rd_wen(n_rd_wen),
    .o_jal(n_jal), .o_jalr(n_jalr), .o_branch_may(n_branch_may),
    .o_nextpc2reg(n_nextpc2reg), .o_alures2reg(n_alures2reg),
    .o_memory2reg(n_memory2reg), .o_mem_write(n_mem_write), .o_muldiv(n_muldiv),
    .o_system(n_system), .o_fence(n_fence), .o_opcode(n_opcode), .o_funct7(n_funct7),
    .o_funct3(n_funct3), .o_illegal(n_illegal)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] ppi;
    logic [4:0]  rs1, rs2, rd;
    logic rs1_en, rs2_en, rd_wen, jal, jalr, br, npc, alu, m2r, mw, md, sys, fen, ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] xfer_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written directly from the instruction-format rules.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input bit m);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         wr;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    wr = 0;
    e = '0;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    case (op)
      7'b0110111, 7'b0010111: begin e.imm = {ins[31:12], 12'h0}; wr = 1; e.alu = 1; end
      7'b1101111: begin
        e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        wr = 1; e.jal = 1; e.npc = 1;
      end
      7'b1100111: begin
        e.imm = {{20{ins[31]}}, ins[31:20]};
        e.rs1_en = 1; wr = 1; e.jalr = 1; e.npc = 1; e.ill = (f3 != 0);
      end
      7'b1100011: begin
        e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.rs1_en = 1; e.rs2_en = 1; e.br = 1; e.ill = (f3 == 2 || f3 == 3);
      end
      7'b0000011: begin
        e.imm = {{20{ins[31]}}, ins[31:20]};
        e.rs1_en = 1; wr = 1; e.m2r = 1; e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'b0100011: begin
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        e.rs1_en = 1; e.rs2_en = 1; e.mw = 1; e.ill = (f3 > 2);
      end
      7'b0010011: begin
        e.imm = {{20{ins[31]}}, ins[31:20]};
        e.rs1_en = 1; wr = 1; e.alu = 1;
        if (f3 == 1) e.ill = (f7 != 0);
        if (f3 == 5) e.ill = !(f7 == 0 || f7 == 7'h20);
      end
      7'b0110011: begin
        e.rs1_en = 1; e.rs2_en = 1; wr = 1; e.alu = 1;
        if (f7 == 7'h01) begin e.md = m; e.ill = !m; end
        else if (f7 == 7'h20) e.ill = !(f3 == 0 || f3 == 5);
        else e.ill = (f7 != 0);
      end
      7'b0001111: e.fen = 1;
      7'b1110011: begin e.sys = 1; e.rs1_en = (f3 != 0); wr = (f3 != 0); end
      default: e.ill = 1;
    endcase
    e.rd_wen = wr && (e.rd != 0) && !e.ill;
    if (e.ill) begin
      e.jal = 0; e.jalr = 0; e.br = 0; e.m2r = 0; e.mw = 0; e.md = 0;
    end
    e.ppi = pc + e.imm;
    return e;
  endfunction

  // Occupancy model: a FIFO of at most two accepted instructions.
  always @(posedge clk or negedge rst_n) begin : mdl
    bit acc;
    bit xf;
    if (!rst_n) q.delete();
    else if (i_flush) q.delete();
    else begin
      acc = i_valid && (q.size() < 2);
      xf  = (q.size() != 0) && i_ready_ex;
      if (xf) void'(q.pop_front());
      if (acc) q.push_back({i_instr, i_pc});
    end
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    exp_t a;
    exp_t en;
    if (chk_en && rst_n) begin
      chk("valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
      chk("ready", {31'd0, i_ready}, {31'd0, q.size() < 2});
      chk("valid_nm", {31'd0, n_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        e = ref_dec(q[0].ins, q[0].pc, 1'b1);
        a = {o_imm, o_pc_plus_imm, o_rs1_addr, o_rs2_addr, o_rd_addr, o_rs1_en, o_rs2_en,
             o_rd_wen, o_jal, o_jalr, o_branch_may, o_nextpc2reg, o_alures2reg,
             o_memory2reg, o_mem_write, o_muldiv, o_system, o_fence, o_illegal};
        n_chk++;
        if (a !== e) begin
          n_err++;
          $display("FAIL decode pc=%h got=%h want=%h", q[0].pc, a, e);
        end
        chk("pc", o_pc, q[0].pc);
        chk("raw", {15'd0, o_opcode, o_funct3, o_funct7},
            {15'd0, q[0].ins[6:0], q[0].ins[14:12], q[0].ins[31:25]});
        en = ref_dec(q[0].ins, q[0].pc, 1'b0);
        chk("nm_flags", {28'd0, n_illegal, n_rd_wen, n_muldiv, n_memory2reg},
            {28'd0, en.ill, en.rd_wen, en.md, en.m2r});
        if (i_ready_ex) xfer_log.push_back(o_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    i_valid = v;
    i_instr = ins;
    i_pc    = pc;
  endtask

  logic [31:0] tbl[22] = '{
    32'h123452B7, 32'h00001317, 32'hFE208CE3, 32'h0020E463, 32'h00412383, 32'hFFF04403,
    32'hFE308F23, 32'h4034D493, 32'h40349493, 32'h40208533, 32'h4020D533, 32'hFFF0B593,
    32'h00000073, 32'h30009673, 32'h0FF0000F, 32'h000280E7, 32'h000290E7, 32'h0020A063,
    32'h0020B023, 32'h40209533, 32'h0220C6B3, 32'hFFF00091
  };

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int cyc;
    bit acc;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, i_ready}, 32'd1);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk_en = 1'b1;
    step();

    // addi x1,x0,-1 then jal x0,-4
    i_ready_ex = 1'b1;
    drive(1, 32'hFFF00093, 32'h100);
    step();
    chk("addi_valid", {31'd0, o_valid}, 32'd1);
    chk("addi_imm", o_imm, 32'hFFFFFFFF);
    chk("addi_flags", {28'd0, o_rd_wen, o_rs1_en, o_rs2_en, o_illegal}, 32'b1100);
    drive(1, 32'hFFDFF06F, 32'h8);
    step();
    chk("jal_imm", o_imm, 32'hFFFFFFFC);
    chk("jal_ppi", o_pc_plus_imm, 32'h4);
    chk("jal_flags", {30'd0, o_rd_wen, o_jal}, 32'b01);
    drive(0, 0, 0);
    step();

    // Stall with three instructions offered: A, B, C
    i_ready_ex = 1'b0;
    xfer_log.delete();
    drive(1, 32'h00500113, 32'h200);
    step();
    drive(1, 32'h002081B3, 32'h204);
    step();
    drive(1, 32'h0020A423, 32'h208);
    step();
    chk("full2_ready", {31'd0, i_ready}, 32'd0);
    chk("full2_pc", o_pc, 32'h200);
    step();
    chk("stall_pc", o_pc, 32'h200);
    i_ready_ex = 1'b1;
    step();
    step();
    drive(0, 0, 0);
    step();
    step();
    chk("order_n", xfer_log.size(), 32'd3);
    if (xfer_log.size() == 3) begin
      chk("order_a", xfer_log[0], 32'h200);
      chk("order_b", xfer_log[1], 32'h204);
      chk("order_c", xfer_log[2], 32'h208);
    end

    // Flush while FULL2
    i_ready_ex = 1'b0;
    drive(1, 32'h00100093, 32'h300);
    step();
    drive(1, 32'h00200093, 32'h304);
    step();
    drive(1, 32'h00300093, 32'h308);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_ready", {31'd0, i_ready}, 32'd1);
    drive(1, 32'h00400093, 32'h30C);
    i_ready_ex = 1'b1;
    step();
    drive(0, 0, 0);
    chk("after_flush_pc", o_pc, 32'h30C);
    step();
    chk("after_flush_alone", {31'd0, o_valid}, 32'd0);

    // Flush beats a same-cycle accept
    i_ready_ex = 1'b0;
    drive(1, 32'h00500093, 32'h310);
    step();
    drive(1, 32'h00600093, 32'h314);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(0, 0, 0);
    chk("flush_acc_valid", {31'd0, o_valid}, 32'd0);
    step();
    chk("flush_acc_valid2", {31'd0, o_valid}, 32'd0);

    // mul, all-zero word, LOAD funct3=011
    i_ready_ex = 1'b1;
    drive(1, 32'h022081B3, 32'h400);
    step();
    chk("mul_m", {30'd0, o_muldiv, o_illegal}, 32'b10);
    chk("mul_nm", {29'd0, n_illegal, n_rd_wen, n_muldiv}, 32'b100);
    drive(1, 32'h00000000, 32'h404);
    step();
    chk("zero_ill", {30'd0, o_illegal, o_memory2reg}, 32'b10);
    drive(1, 32'h0000B083, 32'h408);
    step();
    chk("ld_ill", {29'd0, o_illegal, o_memory2reg, o_rd_wen}, 32'b100);
    drive(0, 0, 0);
    step();

    // Table sweep with a stuttering consumer
    k = 0;
    cyc = 0;
    while (k < 22 && cyc < 300) begin
      drive(1, tbl[k], 32'h1000 + 32'(k * 4));
      i_ready_ex = (cyc % 3) != 0;
      acc = (q.size() < 2);
      step();
      if (acc) k++;
      cyc++;
    end
    chk("sweep_done", k, 32'd22);
    drive(0, 0, 0);
    i_ready_ex = 1'b1;
    repeat (4) step();

    // Asynchronous reset in the middle of a stalled stream
    i_ready_ex = 1'b0;
    drive(1, 32'h00700093, 32'h500);
    step();
    drive(1, 32'h00800093, 32'h504);
    step();
    drive(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_pc", o_pc, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, i_ready}, 32'd1);
    i_ready_ex = 1'b1;
    drive(1, 32'h00900093, 32'h600);
    step();
    drive(0, 0, 0);
    chk("post_rst_pc", o_pc, 32'h600);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
